// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: prediction strategies, NOP encoding and
// BTB saturating-counter constants and helper.
package cpu_pipe_pkg;

   localparam logic [1:0] NOT_TAKEN    = 2'b00;
   localparam logic [1:0] TAKEN        = 2'b01;
   localparam logic [1:0] DELAY_SLOT   = 2'b10;

   localparam logic [31:0] NOP         = 32'h0000_0000;

   localparam logic [1:0] WEAK_TAKEN   = 2'd2;
   localparam logic [1:0] STRONG_TAKEN = 2'd3;

   // Two-bit saturating counter step toward the resolved outcome.
   function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != STRONG_TAKEN) res = ctr + 2'd1;
      end else begin
         if (ctr != 2'd0) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup for the fetch PC,
// one registered training port fed from EX, valid bits cleared by reset.
module branch_target_buffer
   import cpu_pipe_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        lookup_hit,
   output logic [31:0] lookup_target,
   output logic        lookup_pred,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);

   localparam int IW = $clog2(ENTRIES);
   localparam int TW = 30 - IW;

   logic [ENTRIES-1:0] valid_reg;
   logic [TW-1:0]      tag_mem    [ENTRIES];
   logic [31:0]        target_mem [ENTRIES];
   logic [1:0]         ctr_mem    [ENTRIES];

   logic [IW-1:0] l_idx, u_idx;
   logic [TW-1:0] l_tag, u_tag;
   logic          u_hit;
   logic          unused_low_bits;

   assign l_idx = lookup_pc[IW+1:2];
   assign l_tag = lookup_pc[31:IW+2];
   assign u_idx = upd_pc[IW+1:2];
   assign u_tag = upd_pc[31:IW+2];
   assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

   // Lookup reflects contents before any same-cycle training write.
   always_comb begin
      lookup_hit    = valid_reg[l_idx] && (tag_mem[l_idx] == l_tag);
      lookup_target = target_mem[l_idx];
      lookup_pred   = lookup_hit && (ctr_mem[l_idx] >= WEAK_TAKEN);
      u_hit         = valid_reg[u_idx] && (tag_mem[u_idx] == u_tag);
   end

   // Valid bits: cleared by reset, set when a taken branch allocates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
      end else if (upd_en && upd_taken) begin
         valid_reg[u_idx] <= 1'b1;
      end
   end

   // Tag/target/counter storage needs no reset; valid bits gate it.
   always_ff @(posedge clk) begin
      if (upd_en) begin
         if (u_hit) begin
            ctr_mem[u_idx] <= sat_step(ctr_mem[u_idx], upd_taken);
            if (upd_taken) target_mem[u_idx] <= upd_target;
         end else if (upd_taken) begin
            tag_mem[u_idx]    <= u_tag;
            target_mem[u_idx] <= upd_target;
            ctr_mem[u_idx]    <= WEAK_TAKEN;
         end
      end
   end

endmodule

// File: rtl/fetch_predict_stage.sv
// Instruction fetch stage: PC register, next-PC prediction, EX-driven
// redirect/squash and the IF/ID instruction register.
module fetch_predict_stage
   import cpu_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          BTB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  strategy,
   input  logic        stall,
   input  logic        ex_resolve,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] imem_data,
   output logic [31:0] PC,
   output logic [31:0] IFIR,
   output logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic        if_valid,
   output logic        flush_id
);

   logic        btb_hit;
   logic [31:0] btb_target;
   logic        btb_pred;

   logic        pred_taken;
   logic [31:0] next_pc;
   logic        mispredict;
   logic [31:0] redirect_pc;

   branch_target_buffer #(.ENTRIES(BTB_ENTRIES)) u_btb (
      .clk           (clk),
      .rst           (rst),
      .lookup_pc     (PC),
      .lookup_hit    (btb_hit),
      .lookup_target (btb_target),
      .lookup_pred   (btb_pred),
      .upd_en        (ex_resolve),
      .upd_pc        (ex_pc),
      .upd_taken     (ex_taken),
      .upd_target    (ex_target)
   );

   // Prediction, mispredict detection and squash of the ID instruction.
   // In delay-slot mode the ID instruction is the slot and survives.
   always_comb begin
      pred_taken  = (strategy == TAKEN) && btb_hit && btb_pred;
      next_pc     = pred_taken ? btb_target : PC + 32'd4;
      mispredict  = ex_resolve && (ex_taken != ex_pred_taken);
      redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
      flush_id    = !rst && mispredict && (strategy != DELAY_SLOT);
   end

   // PC and IF/ID register: redirect beats stall, stall beats advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC            <= RESET_PC;
         IFIR          <= NOP;
         if_pc         <= 32'h0;
         if_pred_taken <= 1'b0;
         if_valid      <= 1'b0;
      end else if (mispredict) begin
         PC            <= redirect_pc;
         IFIR          <= NOP;
         if_pred_taken <= 1'b0;
         if_valid      <= 1'b0;
      end else if (!stall) begin
         PC            <= next_pc;
         IFIR          <= imem_data;
         if_pc         <= PC;
         if_pred_taken <= pred_taken;
         if_valid      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_predict_stage.sv
// Bench for fetch_predict_stage: directed scenarios followed by random
// traffic, compared every cycle against a behavioural fetch/BTB model.
module tb_fetch_predict_stage;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  strategy;
   logic        stall;
   logic        ex_resolve;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] imem_data;
   logic [31:0] PC, IFIR, if_pc;
   logic        if_pred_taken, if_valid, flush_id;

   logic [31:0] pc2, imem_data2;
   logic [31:0] unused_ifir2, unused_if_pc2;
   logic        unused_pred2, unused_valid2, unused_flush2;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   assign imem_data  = imem(PC);
   assign imem_data2 = imem(pc2);

   fetch_predict_stage u_dut (
      .clk(clk), .rst(rst), .strategy(strategy), .stall(stall),
      .ex_resolve(ex_resolve), .ex_pc(ex_pc), .ex_taken(ex_taken),
      .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .imem_data(imem_data), .PC(PC), .IFIR(IFIR), .if_pc(if_pc),
      .if_pred_taken(if_pred_taken), .if_valid(if_valid), .flush_id(flush_id)
   );

   fetch_predict_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .strategy(2'b00), .stall(1'b0),
      .ex_resolve(1'b0), .ex_pc(32'h0), .ex_taken(1'b0),
      .ex_target(32'h0), .ex_pred_taken(1'b0),
      .imem_data(imem_data2), .PC(pc2), .IFIR(unused_ifir2), .if_pc(unused_if_pc2),
      .if_pred_taken(unused_pred2), .if_valid(unused_valid2), .flush_id(unused_flush2)
   );

   // Behavioural model state
   logic [31:0] m_pc, m_ifir, m_if_pc;
   logic        m_if_pred, m_if_valid;
   bit          m_v   [N];
   logic [31:0] m_tag [N];
   logic [31:0] m_tgt [N];
   int          m_ctr [N];
   logic        last_flush;

   int total = 0;
   int passed = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pc = 32'h0; m_ifir = 32'h0; m_if_pc = 32'h0;
      m_if_pred = 1'b0; m_if_valid = 1'b0;
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
   endtask

   task automatic chk_regs();
      chk("PC", PC, m_pc);
      chk("IFIR", IFIR, m_ifir);
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_if_valid});
      chk("if_pred_taken", {31'b0, if_pred_taken}, {31'b0, m_if_pred});
      if (m_if_valid) chk("if_pc", if_pc, m_if_pc);
   endtask

   // One clock with the inputs currently applied: check flush_id mid-cycle,
   // advance the model on the edge, then check registered outputs.
   task automatic step();
      int idx, eidx;
      logic hit, pred, misp, ehit;
      logic [31:0] nxt;
      @(negedge clk);
      idx  = int'((m_pc >> 2) % N);
      hit  = m_v[idx] && (m_tag[idx] == (m_pc >> 6));
      pred = (strategy == 2'b01) && hit && (m_ctr[idx] >= 2);
      nxt  = pred ? m_tgt[idx] : m_pc + 32'd4;
      misp = ex_resolve && (ex_taken != ex_pred_taken);
      last_flush = flush_id;
      chk("flush_id", {31'b0, flush_id}, {31'b0, misp && (strategy != 2'b10)});
      @(posedge clk);
      if (misp) begin
         m_pc = ex_taken ? ex_target : ex_pc + 32'd4;
         m_ifir = 32'h0; m_if_valid = 1'b0; m_if_pred = 1'b0;
      end else if (!stall) begin
         m_if_pc = m_pc; m_ifir = imem(m_pc); m_if_pred = pred;
         m_if_valid = 1'b1; m_pc = nxt;
      end
      if (ex_resolve) begin
         eidx = int'((ex_pc >> 2) % N);
         ehit = m_v[eidx] && (m_tag[eidx] == (ex_pc >> 6));
         if (ehit) begin
            if (ex_taken) begin
               m_ctr[eidx] = (m_ctr[eidx] < 3) ? m_ctr[eidx] + 1 : 3;
               m_tgt[eidx] = ex_target;
            end else begin
               m_ctr[eidx] = (m_ctr[eidx] > 0) ? m_ctr[eidx] - 1 : 0;
            end
         end else if (ex_taken) begin
            m_v[eidx] = 1'b1; m_tag[eidx] = ex_pc >> 6;
            m_tgt[eidx] = ex_target; m_ctr[eidx] = 2;
         end
      end
      #1;
      chk_regs();
   endtask

   task automatic set_ex(input logic r, input logic [31:0] p, input logic t,
                         input logic [31:0] tg, input logic pt);
      ex_resolve = r; ex_pc = p; ex_taken = t; ex_target = tg; ex_pred_taken = pt;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   logic [31:0] set_vals [8] = '{32'd20, 32'd84, 32'd40, 32'd64, 32'd96, 32'd128, 32'd200, 32'd260};
   logic [31:0] saved_pc, saved_ifir;

   initial begin
      rst = 1'b1; strategy = 2'b00; stall = 1'b0; last_flush = 1'b0;
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      m_reset();
      @(posedge clk); #1;
      chk_regs();
      chk("rst_if_pc", if_pc, 32'h0);
      chk("wrap_reset_pc", pc2, 32'hFFFF_FFFC);
      rst = 1'b0;
      step();
      chk("wrap_pc_0", pc2, 32'h0);
      step();
      chk("wrap_pc_4", pc2, 32'h4);

      // Run to PC=40, then reset asynchronously in the middle of a cycle.
      for (int i = 0; i < 8; i++) step();
      chk("pc_40", PC, 32'd40);
      #2;
      set_ex(1'b1, 32'd20, 1'b1, 32'd96, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_rst_pc", PC, 32'h0);
      chk("async_rst_ifir", IFIR, 32'h0);
      chk("async_rst_valid", {31'b0, if_valid}, 32'h0);
      chk("async_rst_flush", {31'b0, flush_id}, 32'h0);
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      chk("post_rst_pc4", PC, 32'd4);
      chk("post_rst_ifir_lag", IFIR, imem(32'd0));
      step(); step(); step(); step();

      // Strategy 00: taken branch resolved at 20.
      set_ex(1'b1, 32'd20, 1'b1, 32'd96, 1'b0);
      step();
      chk("s00_flush", {31'b0, last_flush}, 32'h1);
      chk("s00_pc", PC, 32'd96);
      chk("s00_ifir_nop", IFIR, 32'h0);

      // Strategy 01: allocate, predict, decay the counter.
      do_reset();
      strategy = 2'b01;
      set_ex(1'b1, 32'd20, 1'b1, 32'd96, 1'b0); step();
      set_ex(1'b1, 32'd16, 1'b0, 32'd0, 1'b1);  step();
      chk("s01_pc20", PC, 32'd20);
      set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);   step();
      chk("s01_pred_pc", PC, 32'd96);
      chk("s01_pred_bit", {31'b0, if_pred_taken}, 32'h1);
      set_ex(1'b1, 32'd20, 1'b0, 32'd0, 1'b1);  step();
      chk("s01_nt_pc", PC, 32'd24);
      chk("s01_nt_flush", {31'b0, last_flush}, 32'h1);
      step();
      set_ex(1'b1, 32'd16, 1'b0, 32'd0, 1'b1);  step();
      set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);   step();
      chk("s01_weak_pc", PC, 32'd24);
      chk("s01_weak_pred", {31'b0, if_pred_taken}, 32'h0);

      // Strategy 10: delay slot keeps ID.
      strategy = 2'b10;
      set_ex(1'b1, 32'd20, 1'b1, 32'd96, 1'b0); step();
      chk("s10_flush", {31'b0, last_flush}, 32'h0);
      chk("s10_pc", PC, 32'd96);
      chk("s10_valid", {31'b0, if_valid}, 32'h0);
      set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);   step();

      // Stall holds, then stall with a redirect: redirect wins.
      strategy = 2'b00;
      saved_pc = m_pc; saved_ifir = m_ifir;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("stall_pc", PC, saved_pc);
      chk("stall_ifir", IFIR, saved_ifir);
      set_ex(1'b1, 32'd200, 1'b1, 32'd64, 1'b0); step();
      chk("stall_redirect_pc", PC, 32'd64);
      stall = 1'b0;
      set_ex(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         if (c % 25 == 0) strategy = 2'($urandom_range(0, 3));
         stall = ($urandom_range(0, 3) == 0);
         set_ex($urandom_range(0, 2) == 0, set_vals[$urandom_range(0, 7)],
                1'($urandom_range(0, 1)), set_vals[$urandom_range(0, 7)],
                1'($urandom_range(0, 1)));
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_predict_stage.md
# fetch_predict_stage

Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the decode stage. Owns the PC register and the IF/ID instruction register. Predicts the next PC using the selectable branch-prediction strategy: not-taken, BTB-taken, or delay-slot. Takes branch resolution from EX and redirects the PC, squashes wrong-path work, and trains the BTB.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset.
- `BTB_ENTRIES`, default 16: direct-mapped BTB depth; power of two.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `strategy` in 2: prediction strategy.
  - 00: not-taken.
  - 01: taken, via BTB.
  - 10: delay slot.
  - 11: behaves as 00.
- `stall` in 1: hold request from the ID hazard unit (load-use).
- `ex_resolve` in 1: a branch or jump is resolved in EX this cycle.
- `ex_pc` in 32: PC of the resolving instruction.
- `ex_taken` in 1: actual outcome.
- `ex_target` in 32: actual taken target.
- `ex_pred_taken` in 1: prediction carried down the pipe with that instruction.
- `imem_data` in 32: combinational instruction-memory read of `PC`.
- `PC` out 32: current fetch address; also drives the instruction-memory address.
- `IFIR` out 32: instruction register to ID.
- `if_pc` out 32: PC of the instruction in `IFIR`.
- `if_pred_taken` out 1: prediction made for the `IFIR` instruction.
- `if_valid` out 1: `IFIR` holds a real instruction.
- `flush_id` out 1: combinational; squash the instruction currently in ID.

## Operation
- **BTB entry:** valid, tag = PC[31:2+log2(BTB_ENTRIES)], target[31:0], 2-bit saturating counter (0–3).
- **BTB index:** PC[log2(BTB_ENTRIES)+1:2].
- **Prediction:**
  - `pred_taken` = (strategy==01) & hit & counter>=2.
  - `next_pc` = pred_taken ? btb_target : PC+4. Adds wrap mod 2^32.
- **Mispredict:** `mispredict` = ex_resolve & (ex_taken != ex_pred_taken).
- **Redirect target:** ex_taken ? ex_target : ex_pc+4.
- **Squash scope:**
  - Strategy 00/01/11: on mispredict, squash IF and ID. The next `IFIR` becomes a bubble and `flush_id`=1.
  - Strategy 10: the ID-stage instruction is the delay slot and is kept (`flush_id`=0). Only the IF instruction is squashed. Prediction is always not-taken, so a mispredict is a taken branch.
- **Update priority, per cycle:** `rst` > mispredict redirect > `stall` > normal advance.
  - Redirect: `PC`<=corrected PC; `IFIR`<=0 (NOP); `if_valid`<=0; `if_pred_taken`<=0.
  - Stall: `PC`, `IFIR`, `if_pc`, `if_pred_taken`, `if_valid` all hold.
  - Advance: `PC`<=next_pc; `IFIR`<=imem_data; `if_pc`<=PC; `if_pred_taken`<=pred_taken; `if_valid`<=1.
- **BTB training:** on every `ex_resolve`, independent of stall and strategy.
  - Hit, taken: counter+1, saturating at 3; target<=ex_target.
  - Hit, not-taken: counter−1, saturating at 0.
  - Miss, taken: allocate entry (overwrite the index); counter=2; target=ex_target.
  - Miss, not-taken: no change.
- **Reset:** BTB valid bits cleared. Tags, targets and counters are don't-care.

## Timing
- Reset values, applied asynchronously while `rst`=1:
  - `PC`=RESET_PC.
  - `IFIR`=0, `if_pc`=0, `if_pred_taken`=0, `if_valid`=0.
  - `flush_id`=0.
- Fetch latency: `imem_data` for `PC` appears in `IFIR` one cycle later.
- Redirect: the corrected PC is visible the cycle after `ex_resolve`. Mispredict penalty is 2 cycles (1 in strategy 10).
- `flush_id` is asserted combinationally in the same cycle as the mispredicting `ex_resolve`.
- BTB read and write to the same index in one cycle: the lookup returns pre-write contents; the write lands at the clock edge.
- `rst` asserted mid-operation aborts any pending redirect.

## Structure
- Shared package `cpu_pipe_pkg` holds:
  - strategy constants: NOT_TAKEN=2'b00, TAKEN=2'b01, DELAY_SLOT=2'b10.
  - NOP=32'h0.
  - counter constants WEAK_TAKEN=2, STRONG_TAKEN=3.
- Sub-module `branch_target_buffer`:
  - combinational lookup (hit, target, pred);
  - one registered update port;
  - asynchronous clear of valid bits.
- The PC/IFIR register logic lives in the top module.

## Test plan
- **Reset mid-run:** `rst`=1 while `PC`=40 -> `PC`=0, `IFIR`=0, `if_valid`=0 immediately. Then `PC` runs 0,4,8, and `IFIR` lags `PC` by one cycle.
- **Strategy 00, taken branch:** `ex_resolve`, ex_pc=20, ex_taken=1, ex_target=96, ex_pred_taken=0 -> `flush_id`=1 that cycle; next `PC`=96, `IFIR`=0, `if_valid`=0.
- **Strategy 01, BTB training:**
  - Taken resolve at pc 20 -> 96 allocates the entry.
  - Next fetch at `PC`=20 -> next `PC`=96, `if_pred_taken`=1.
  - Two not-taken resolves take the counter 2->1->0 (the first after allocation leaves it at 1). The next fetch at 20 predicts not-taken (`PC`=24).
  - Resolve not-taken with pred=1 -> `PC`<=24 and `flush_id`=1.
- **Strategy 10, taken branch:** taken branch at 20 -> `flush_id`=0, IF squashed, `PC`=target next cycle.
- **Stall with simultaneous redirect:** `stall`=1 for 3 cycles holds `PC`/`IFIR` unchanged. `stall`=1 together with a mispredicting `ex_resolve` -> the redirect wins.
- **PC wrap:** RESET_PC=32'hFFFFFFFC, no branches -> `PC` goes FFFFFFFC then 0.
